// File: rtl/branch_target_buffer.sv
// Set-associative branch target buffer for the fetch stage.
// The fetch PC is looked up and the result is registered, so it appears one
// cycle after the strobe. The execute stage trains entries in place, and a
// new entry is allocated only when a branch is taken. Replacement is true LRU,
// using per-set age fields where 0 is MRU and WAY_N-1 is LRU.
//
// Handshake: iSEARCH_STB and iUPDATE_STB are single-cycle strobes with no
// ready/backpressure. Every search strobe produces exactly one oSEARCH_VALID
// pulse on the following cycle. All result outputs are zero whenever
// oSEARCH_VALID is low.
//
// Legal parameter values: WAY_N in {1,2,4,8}, CNT_W in 2..4.
module branch_target_buffer #(
    parameter  int SET_W  = 3,
    parameter  int WAY_N  = 2,
    parameter  int CNT_W  = 2,
    parameter  int ADDR_W = 32,
    localparam int WAY_W  = (WAY_N > 1) ? $clog2(WAY_N) : 1
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iFLUSH,
    input  logic              iSEARCH_STB,
    input  logic [ADDR_W-1:0] iSEARCH_INST_ADDR,
    output logic              oSEARCH_VALID,
    output logic              oSEARCH_HIT,
    output logic              oSEARCH_PREDICT_TAKEN,
    output logic [ADDR_W-1:0] oSEARCH_TARGET,
    output logic [WAY_W-1:0]  oSEARCH_WAY,
    input  logic              iUPDATE_STB,
    input  logic              iUPDATE_TAKEN,
    input  logic [ADDR_W-1:0] iUPDATE_INST_ADDR,
    input  logic [ADDR_W-1:0] iUPDATE_TARGET
);

    localparam int SETS  = 1 << SET_W;
    localparam int TAG_W = ADDR_W - SET_W - 2;
    localparam int AGE_W = WAY_W;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};

    // Storage arrays. Only the valid bits and the ages are reset.
    logic [WAY_N-1:0]  valid_q  [SETS];
    logic [TAG_W-1:0]  tag_q    [SETS][WAY_N];
    logic [ADDR_W-1:0] target_q [SETS][WAY_N];
    logic [CNT_W-1:0]  cnt_q    [SETS][WAY_N];
    logic [AGE_W-1:0]  age_q    [SETS][WAY_N];

    // Request decode
    logic [SET_W-1:0] s_set, u_set;
    logic [TAG_W-1:0] s_tag, u_tag;

    assign s_set = iSEARCH_INST_ADDR[SET_W+1:2];
    assign s_tag = iSEARCH_INST_ADDR[ADDR_W-1:SET_W+2];
    assign u_set = iUPDATE_INST_ADDR[SET_W+1:2];
    assign u_tag = iUPDATE_INST_ADDR[ADDR_W-1:SET_W+2];

    // Search-side lookup signals
    logic              s_hit;
    logic [WAY_W-1:0]  s_way;
    logic [ADDR_W-1:0] s_target;
    logic              s_cnt_msb;
    logic              s_touch;
    logic [AGE_W-1:0]  s_old_age;
    logic [AGE_W-1:0]  s_age_nxt [WAY_N];

    // Update-side lookup signals
    logic              u_hit;
    logic [WAY_W-1:0]  u_way;
    logic [CNT_W-1:0]  u_cnt;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  u_wway;
    logic [WAY_N-1:0]  u_onehot;
    logic              u_write;
    logic [CNT_W-1:0]  u_cnt_nxt;
    logic [AGE_W-1:0]  u_old_age;
    logic [AGE_W-1:0]  u_age_nxt [WAY_N];

    // Search lookup: the descending scan lets the lowest matching way win
    always_comb begin
        s_hit     = 1'b0;
        s_way     = '0;
        s_target  = '0;
        s_cnt_msb = 1'b0;
        for (int w = WAY_N - 1; w >= 0; w--) begin
            if (valid_q[s_set][w] && (tag_q[s_set][w] == s_tag)) begin
                s_hit     = 1'b1;
                s_way     = WAY_W'(w);
                s_target  = target_q[s_set][w];
                s_cnt_msb = cnt_q[s_set][w][CNT_W-1];
            end
        end
    end

    // Update lookup, victim choice, and next counter value
    always_comb begin
        u_hit  = 1'b0;
        u_way  = '0;
        u_cnt  = '0;
        victim = '0;
        for (int w = WAY_N - 1; w >= 0; w--) begin
            if (valid_q[u_set][w] && (tag_q[u_set][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
                u_cnt = cnt_q[u_set][w];
            end
        end
        // The oldest way is the fallback victim.
        for (int w = WAY_N - 1; w >= 0; w--) begin
            if (age_q[u_set][w] == AGE_W'(WAY_N - 1)) victim = WAY_W'(w);
        end
        // The lowest invalid way takes precedence over the LRU way.
        for (int w = WAY_N - 1; w >= 0; w--) begin
            if (!valid_q[u_set][w]) victim = WAY_W'(w);
        end

        u_wway  = u_hit ? u_way : victim;
        u_write = iUPDATE_STB && !iFLUSH && (u_hit || iUPDATE_TAKEN);

        for (int w = 0; w < WAY_N; w++) begin
            u_onehot[w] = (WAY_W'(w) == u_wway);
        end

        if (!u_hit) begin
            u_cnt_nxt = CNT_WEAK;
        end else if (iUPDATE_TAKEN) begin
            u_cnt_nxt = (u_cnt == CNT_MAX) ? u_cnt : u_cnt + CNT_W'(1);
        end else begin
            u_cnt_nxt = (u_cnt == '0) ? u_cnt : u_cnt - CNT_W'(1);
        end
    end

    // LRU touch for both sides: the touched way goes to 0, and younger ways age by 1
    always_comb begin
        u_old_age = '0;
        s_old_age = '0;
        for (int w = 0; w < WAY_N; w++) begin
            if (u_onehot[w]) u_old_age = age_q[u_set][w];
            if (WAY_W'(w) == s_way) s_old_age = age_q[s_set][w];
        end
        for (int w = 0; w < WAY_N; w++) begin
            u_age_nxt[w] = age_q[u_set][w];
            if (u_onehot[w]) begin
                u_age_nxt[w] = '0;
            end else if (age_q[u_set][w] < u_old_age) begin
                u_age_nxt[w] = age_q[u_set][w] + AGE_W'(1);
            end

            s_age_nxt[w] = age_q[s_set][w];
            if (WAY_W'(w) == s_way) begin
                s_age_nxt[w] = '0;
            end else if (age_q[s_set][w] < s_old_age) begin
                s_age_nxt[w] = age_q[s_set][w] + AGE_W'(1);
            end
        end
        // An update touching the same set owns that set's ages this cycle.
        s_touch = iSEARCH_STB && s_hit && !iFLUSH && !(u_write && (u_set == s_set));
    end

    // Valid bits and LRU ages: async reset, flush, then update/search touches
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAY_N; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else if (iFLUSH) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAY_N; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            if (u_write) begin
                valid_q[u_set] <= valid_q[u_set] | u_onehot;
                for (int w = 0; w < WAY_N; w++) age_q[u_set][w] <= u_age_nxt[w];
            end
            if (s_touch) begin
                for (int w = 0; w < WAY_N; w++) age_q[s_set][w] <= s_age_nxt[w];
            end
        end
    end

    // Entry payload writes: tag on allocation, target on taken, counter always
    always_ff @(posedge iCLOCK) begin
        if (u_write) begin
            for (int w = 0; w < WAY_N; w++) begin
                if (u_onehot[w]) begin
                    if (!u_hit)        tag_q[u_set][w]    <= u_tag;
                    if (iUPDATE_TAKEN) target_q[u_set][w] <= iUPDATE_TARGET;
                    cnt_q[u_set][w] <= u_cnt_nxt;
                end
            end
        end
    end

    // Registered search result: pre-update view, with hits masked by a same-cycle flush
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oSEARCH_VALID         <= 1'b0;
            oSEARCH_HIT           <= 1'b0;
            oSEARCH_PREDICT_TAKEN <= 1'b0;
            oSEARCH_TARGET        <= '0;
            oSEARCH_WAY           <= '0;
        end else begin
            oSEARCH_VALID         <= iSEARCH_STB;
            oSEARCH_HIT           <= iSEARCH_STB && s_hit && !iFLUSH;
            oSEARCH_PREDICT_TAKEN <= iSEARCH_STB && s_hit && !iFLUSH && s_cnt_msb;
            oSEARCH_TARGET        <= (iSEARCH_STB && s_hit && !iFLUSH) ? s_target : '0;
            oSEARCH_WAY           <= (iSEARCH_STB && s_hit && !iFLUSH) ? s_way : '0;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer.
// dut0 uses the default configuration (8 sets, 2 ways).
// dut1 uses 4 sets and 4 ways to exercise LRU replacement.
module tb_branch_target_buffer;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut0 signals
  logic        f0, ss0, us0, ut0;
  logic [31:0] sa0, ua0, utg0;
  logic        v0, h0, p0;
  logic [31:0] t0;
  logic [0:0]  w0;

  // dut1 signals
  logic        f1, ss1, us1, ut1;
  logic [31:0] sa1, ua1, utg1;
  logic        v1, h1, p1;
  logic [31:0] t1;
  logic [1:0]  w1;

  branch_target_buffer dut0 (
    .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(f0),
    .iSEARCH_STB(ss0), .iSEARCH_INST_ADDR(sa0),
    .oSEARCH_VALID(v0), .oSEARCH_HIT(h0), .oSEARCH_PREDICT_TAKEN(p0),
    .oSEARCH_TARGET(t0), .oSEARCH_WAY(w0),
    .iUPDATE_STB(us0), .iUPDATE_TAKEN(ut0),
    .iUPDATE_INST_ADDR(ua0), .iUPDATE_TARGET(utg0)
  );

  branch_target_buffer #(.SET_W(2), .WAY_N(4), .CNT_W(2), .ADDR_W(32)) dut1 (
    .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(f1),
    .iSEARCH_STB(ss1), .iSEARCH_INST_ADDR(sa1),
    .oSEARCH_VALID(v1), .oSEARCH_HIT(h1), .oSEARCH_PREDICT_TAKEN(p1),
    .oSEARCH_TARGET(t1), .oSEARCH_WAY(w1),
    .iUPDATE_STB(us1), .iUPDATE_TAKEN(ut1),
    .iUPDATE_INST_ADDR(ua1), .iUPDATE_TARGET(utg1)
  );

  // vector record: one cycle of stimulus plus the expected search result
  typedef struct {
    bit          dut;
    bit          srch;
    bit          upd;
    bit          flush;
    logic [31:0] saddr;
    logic [31:0] uaddr;
    bit          utaken;
    logic [31:0] utgt;
    bit          ehit;
    bit          etaken;
    logic [31:0] etgt;
    int          eway;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t vs(bit d, logic [31:0] a, bit hit, bit tk, logic [31:0] tgt, int way);
    vec_t v;
    v = '{dut: d, srch: 1'b1, upd: 1'b0, flush: 1'b0, saddr: a, uaddr: '0, utaken: 1'b0,
          utgt: '0, ehit: hit, etaken: tk, etgt: tgt, eway: way};
    return v;
  endfunction

  function automatic vec_t vu(bit d, logic [31:0] a, bit tk, logic [31:0] tgt);
    vec_t v;
    v = '{dut: d, srch: 1'b0, upd: 1'b1, flush: 1'b0, saddr: '0, uaddr: a, utaken: tk,
          utgt: tgt, ehit: 1'b0, etaken: 1'b0, etgt: '0, eway: 0};
    return v;
  endfunction

  function automatic vec_t add_upd(vec_t vin, logic [31:0] a, bit tk, logic [31:0] tgt);
    vec_t v;
    v = vin;
    v.upd = 1'b1;
    v.uaddr = a;
    v.utaken = tk;
    v.utgt = tgt;
    return v;
  endfunction

  // driver tasks
  task automatic drive_idle();
    f0 = 0; ss0 = 0; us0 = 0; ut0 = 0; sa0 = '0; ua0 = '0; utg0 = '0;
    f1 = 0; ss1 = 0; us1 = 0; ut1 = 0; sa1 = '0; ua1 = '0; utg1 = '0;
  endtask

  task automatic drive(vec_t v);
    drive_idle();
    if (v.dut == 1'b0) begin
      f0 = v.flush; ss0 = v.srch; sa0 = v.saddr;
      us0 = v.upd; ut0 = v.utaken; ua0 = v.uaddr; utg0 = v.utgt;
    end else begin
      f1 = v.flush; ss1 = v.srch; sa1 = v.saddr;
      us1 = v.upd; ut1 = v.utaken; ua1 = v.uaddr; utg1 = v.utgt;
    end
  endtask

  // scoreboard compare
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_result(vec_t v, int idx);
    logic        av, ah, ap;
    logic [31:0] at, aw;
    av = v.dut ? v1 : v0;
    ah = v.dut ? h1 : h0;
    ap = v.dut ? p1 : p0;
    at = v.dut ? t1 : t0;
    aw = v.dut ? {30'b0, w1} : {31'b0, w0};
    if (v.srch) begin
      chk($sformatf("v%0d valid", idx), {31'b0, av}, 32'd1);
      chk($sformatf("v%0d hit", idx), {31'b0, ah}, {31'b0, v.ehit});
      chk($sformatf("v%0d taken", idx), {31'b0, ap}, {31'b0, v.etaken});
      chk($sformatf("v%0d target", idx), at, v.etgt);
      chk($sformatf("v%0d way", idx), aw, v.eway);
    end else begin
      chk($sformatf("v%0d valid_idle", idx), {31'b0, av}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    int   n;

    // --- dut0: counter behaviour on a single entry (PC 0x100, set 0) ---
    vecs.push_back(vs(0, 32'h100, 0, 0, 32'h0, 0));          // cold miss
    vecs.push_back(vu(0, 32'h100, 1, 32'h2000));              // allocate way0, cnt=2
    vecs.push_back(vs(0, 32'h100, 1, 1, 32'h2000, 0));
    vecs.push_back(vu(0, 32'h100, 0, 32'hDEAD0));             // cnt=1, target kept
    vecs.push_back(vu(0, 32'h100, 0, 32'hDEAD0));             // cnt=0
    vecs.push_back(vs(0, 32'h100, 1, 0, 32'h2000, 0));
    vecs.push_back(vu(0, 32'h100, 0, 32'hDEAD0));             // stays 0
    vecs.push_back(vu(0, 32'h100, 1, 32'h2100));              // 1
    vecs.push_back(vu(0, 32'h100, 1, 32'h2100));              // 2
    vecs.push_back(vs(0, 32'h100, 1, 1, 32'h2100, 0));
    vecs.push_back(vu(0, 32'h100, 1, 32'h2100));              // 3
    vecs.push_back(vu(0, 32'h100, 1, 32'h2100));              // stays 3
    vecs.push_back(vu(0, 32'h100, 0, 32'hDEAD0));             // 2
    vecs.push_back(vs(0, 32'h100, 1, 1, 32'h2100, 0));
    // --- dut0: 2-way replacement in set 0 ---
    vecs.push_back(vu(0, 32'h200, 1, 32'h3000));              // way1
    vecs.push_back(vu(0, 32'h100, 1, 32'h2100));              // hit way0 -> MRU
    vecs.push_back(vu(0, 32'h300, 1, 32'h4000));              // evicts 0x200 in way1
    vecs.push_back(vs(0, 32'h100, 1, 1, 32'h2100, 0));
    vecs.push_back(vs(0, 32'h300, 1, 1, 32'h4000, 1));
    vecs.push_back(vs(0, 32'h200, 0, 0, 32'h0, 0));
    // --- dut0: not-taken miss allocates nothing ---
    vecs.push_back(vu(0, 32'h400, 0, 32'h9000));
    vecs.push_back(vs(0, 32'h400, 0, 0, 32'h0, 0));
    // --- dut0: same-cycle search/update, same set: read-before-write ---
    vecs.push_back(add_upd(vs(0, 32'h500, 0, 0, 32'h0, 0), 32'h500, 1, 32'h5000)); // victim way0
    vecs.push_back(vs(0, 32'h500, 1, 1, 32'h5000, 0));
    vecs.push_back(vs(0, 32'h100, 0, 0, 32'h0, 0));
    vecs.push_back(vs(0, 32'h300, 1, 1, 32'h4000, 1));        // way1 MRU
    // search hit on way0 collides with update hit on way1; the update touch wins
    vecs.push_back(add_upd(vs(0, 32'h500, 1, 1, 32'h5000, 0), 32'h300, 1, 32'h4000));
    vecs.push_back(vu(0, 32'h600, 1, 32'h6000));              // victim way0 (0x500)
    vecs.push_back(vs(0, 32'h500, 0, 0, 32'h0, 0));
    vecs.push_back(vs(0, 32'h300, 1, 1, 32'h4000, 1));
    vecs.push_back(vs(0, 32'h600, 1, 1, 32'h6000, 0));
    // --- dut0: flush with same-cycle search and update ---
    v = add_upd(vs(0, 32'h300, 0, 0, 32'h0, 0), 32'h700, 1, 32'h7000);
    v.flush = 1'b1;
    vecs.push_back(v);
    vecs.push_back(vs(0, 32'h300, 0, 0, 32'h0, 0));
    vecs.push_back(vs(0, 32'h600, 0, 0, 32'h0, 0));
    vecs.push_back(vs(0, 32'h700, 0, 0, 32'h0, 0));
    // --- dut1: 4-way LRU in set 0 ---
    vecs.push_back(vu(1, 32'h10, 1, 32'h110));                // way0
    vecs.push_back(vu(1, 32'h20, 1, 32'h120));                // way1
    vecs.push_back(vu(1, 32'h30, 1, 32'h130));                // way2
    vecs.push_back(vu(1, 32'h40, 1, 32'h140));                // way3; ages 3,2,1,0
    vecs.push_back(vs(1, 32'h10, 1, 1, 32'h110, 0));          // ages 0,3,2,1
    vecs.push_back(vs(1, 32'h30, 1, 1, 32'h130, 2));          // ages 1,3,0,2
    vecs.push_back(vu(1, 32'h50, 1, 32'h150));                // replaces way1
    vecs.push_back(vs(1, 32'h20, 0, 0, 32'h0, 0));
    vecs.push_back(vs(1, 32'h50, 1, 1, 32'h150, 1));
    vecs.push_back(vs(1, 32'h40, 1, 1, 32'h140, 3));

    // reset
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst valid0", {31'b0, v0}, 32'd0);
    chk("rst hit0", {31'b0, h0}, 32'd0);
    chk("rst target0", t0, 32'd0);
    chk("rst valid1", {31'b0, v1}, 32'd0);
    chk("rst way1", {30'b0, w1}, 32'd0);

    // table-driven run: drive vector i and check vector i-1 on each falling edge
    n = vecs.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) check_result(vecs[i-1], i-1);
      if (i < n) drive(vecs[i]);
      else drive_idle();
    end

    // single-cycle valid pulse
    @(negedge clk);
    v = vs(0, 32'h300, 0, 0, 32'h0, 0);
    drive(v);
    @(negedge clk);
    drive_idle();
    check_result(v, 100);
    @(negedge clk);
    chk("pulse valid_low", {31'b0, v0}, 32'd0);

    // reset while a result is pending clears it, and nothing reappears after release
    drive(v);
    @(posedge clk);
    #1;
    chk("mid pending_valid", {31'b0, v0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst_valid", {31'b0, v0}, 32'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid post_valid", {31'b0, v0}, 32'd0);
    chk("mid post_hit", {31'b0, h0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
